// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between the MIPS core and a DMA/debug
// requester: one transaction per IDLE->ISSUE->RESP->DONE pass, core priority with DMA anti-starvation.
module mem_port_arbiter #(
    parameter int unsigned N            = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rstb,

    input  logic         core_req,
    input  logic         core_we,
    input  logic [N-1:0] core_addr,
    input  logic [N-1:0] core_wdata,
    output logic         core_ack,
    output logic [N-1:0] core_rdata,

    input  logic         dma_req,
    input  logic         dma_we,
    input  logic [N-1:0] dma_addr,
    input  logic [N-1:0] dma_wdata,
    output logic         dma_ack,
    output logic [N-1:0] dma_rdata,

    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wr_data,
    output logic         mem_wr_ena,
    input  logic [N-1:0] mem_rd_data,

    output logic         busy,
    output logic         owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [N-1:0]  addr_q, addr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [N-1:0]  core_rdata_q, core_rdata_d;
    logic [N-1:0]  dma_rdata_q, dma_rdata_d;
    logic          grant_dma;

    // DMA wins when alone, or on a tie once the core has had LIMIT consecutive tie wins.
    assign grant_dma = dma_req && (!core_req || (starve_q >= LIMIT));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        starve_d     = starve_q;
        core_rdata_d = core_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (core_req || dma_req) begin
                    state_d = S_ISSUE;
                    owner_d = grant_dma;
                    if (grant_dma) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end else begin
                        we_d    = core_we;
                        addr_d  = core_addr;
                        wdata_d = core_wdata;
                    end
                    if (core_req && dma_req && !grant_dma) begin
                        starve_d = starve_q + CW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_DONE;
                if (!we_q) begin
                    if (owner_q) begin
                        dma_rdata_d = mem_rd_data;
                    end else begin
                        core_rdata_d = mem_rd_data;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_q     <= '0;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            starve_q     <= starve_d;
            core_rdata_q <= core_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Decoded straight from state so an async reset drops the write strobe at once.
    assign mem_wr_ena  = (state_q == S_ISSUE) && we_q;
    assign core_ack    = (state_q == S_DONE) && !owner_q;
    assign dma_ack     = (state_q == S_DONE) && owner_q;
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign core_rdata  = core_rdata_q;
    assign dma_rdata   = dma_rdata_q;

endmodule
